hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_if.sv | 31 +++
 rtl/hazard_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-unit bundle: ID/EX operand info in, forwarding selects and
// pipeline control out. wb_dest/wb_rw expose the MEM->WB shadow for observation.
interface hazard_ctrl_if;
  logic       id_valid;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_branch_taken;
  logic [4:0] ex_dest;
  logic       ex_reg_write;
  logic       ex_mem_read;
  logic       ex_muldiv;
  logic [2:0] fwdA;
  logic [2:0] fwdB;
  logic       stall;
  logic       flush;
  logic       md_busy;
  logic [4:0] wb_dest;
  logic       wb_rw;

  modport master (
    output id_valid, id_rs, id_rt, id_branch_taken,
    output ex_dest, ex_reg_write, ex_mem_read, ex_muldiv,
    input  fwdA, fwdB, stall, flush, md_busy, wb_dest, wb_rw
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_branch_taken,
    input  ex_dest, ex_reg_write, ex_mem_read, ex_muldiv,
    output fwdA, fwdB, stall, flush, md_busy, wb_dest, wb_rw
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard detection and forwarding control for a 5-stage pipeline.
// Define HAZARD_MULDIV_EN to enable the 4-cycle multi-cycle mul/div stall (MD_BUSY).
module hazard_ctrl (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave hif
);

  localparam logic [1:0] ST_RUN      = 2'b00;
  localparam logic [1:0] ST_LD_STALL = 2'b01;
`ifdef HAZARD_MULDIV_EN
  localparam logic [1:0] ST_MD_BUSY  = 2'b10;
`endif

  localparam logic [2:0] FWD_ID_EX  = 3'b001;
  localparam logic [2:0] FWD_EX_MEM = 3'b010;
  localparam logic [2:0] FWD_MEM_WB = 3'b100;

  // Newest producer wins; register 0 is never forwarded.
  function automatic logic [2:0] fwd_sel(
    input logic [4:0] src,
    input logic [4:0] ex_dest,
    input logic       ex_rw,
    input logic [4:0] mem_dest,
    input logic       mem_rw
  );
    logic [2:0] sel;
    if (ex_rw && (ex_dest != 5'd0) && (ex_dest == src)) begin
      sel = FWD_EX_MEM;
    end else if (mem_rw && (mem_dest != 5'd0) && (mem_dest == src)) begin
      sel = FWD_MEM_WB;
    end else begin
      sel = FWD_ID_EX;
    end
    return sel;
  endfunction

  logic [1:0] state_q,    state_d;
  logic [2:0] fwd_a_q,    fwd_a_d;
  logic [2:0] fwd_b_q,    fwd_b_d;
  logic [4:0] mem_dest_q, mem_dest_d;
  logic       mem_rw_q,   mem_rw_d;
  logic [4:0] wb_dest_q,  wb_dest_d;
  logic       wb_rw_q,    wb_rw_d;
  logic       md_busy_q,  md_busy_d;
`ifdef HAZARD_MULDIV_EN
  logic [1:0] md_cnt_q,   md_cnt_d;
`endif

  logic load_use_s;
  logic md_start_s;
  logic in_md_s;
  logic stall_raw_s;
  logic flush_raw_s;

  assign load_use_s = hif.id_valid && hif.ex_mem_read && (hif.ex_dest != 5'd0) &&
                      ((hif.ex_dest == hif.id_rs) || (hif.ex_dest == hif.id_rt));

`ifdef HAZARD_MULDIV_EN
  assign md_start_s = hif.ex_muldiv;
  assign in_md_s    = (state_q == ST_MD_BUSY);
`else
  logic muldiv_unused_s;
  assign muldiv_unused_s = hif.ex_muldiv;
  assign md_start_s      = 1'b0;
  assign in_md_s         = 1'b0;
`endif

  // Next-state, forwarding select and shadow pipeline computation.
  always_comb begin
    state_d     = state_q;
    stall_raw_s = 1'b0;
`ifdef HAZARD_MULDIV_EN
    md_cnt_d    = md_cnt_q;
`endif
    case (state_q)
      ST_RUN: begin
`ifdef HAZARD_MULDIV_EN
        if (md_start_s) begin
          state_d  = ST_MD_BUSY;
          md_cnt_d = 2'd3;
        end else
`endif
        if (load_use_s) begin
          state_d     = ST_LD_STALL;
          stall_raw_s = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_LD_STALL: begin
        state_d = ST_RUN;
      end
`ifdef HAZARD_MULDIV_EN
      ST_MD_BUSY: begin
        stall_raw_s = 1'b1;
        if (md_cnt_q == 2'd0) begin
          state_d = ST_RUN;
        end else begin
          md_cnt_d = md_cnt_q - 2'd1;
        end
      end
`endif
      default: begin
        state_d = ST_RUN;
      end
    endcase

    flush_raw_s = hif.id_valid && hif.id_branch_taken && !stall_raw_s;

    // Selects freeze while the mul/div occupies EX; bubbles carry the neutral select.
    if (in_md_s) begin
      fwd_a_d = fwd_a_q;
      fwd_b_d = fwd_b_q;
    end else if (!hif.id_valid || stall_raw_s || flush_raw_s) begin
      fwd_a_d = FWD_ID_EX;
      fwd_b_d = FWD_ID_EX;
    end else begin
      fwd_a_d = fwd_sel(hif.id_rs, hif.ex_dest, hif.ex_reg_write, mem_dest_q, mem_rw_q);
      fwd_b_d = fwd_sel(hif.id_rt, hif.ex_dest, hif.ex_reg_write, mem_dest_q, mem_rw_q);
    end

    if (in_md_s) begin
      mem_dest_d = 5'd0;
      mem_rw_d   = 1'b0;
    end else begin
      mem_dest_d = hif.ex_dest;
      mem_rw_d   = hif.ex_reg_write;
    end
    wb_dest_d = mem_dest_q;
    wb_rw_d   = mem_rw_q;

`ifdef HAZARD_MULDIV_EN
    md_busy_d = (state_d == ST_MD_BUSY);
`else
    md_busy_d = 1'b0;
`endif
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      fwd_a_q    <= FWD_ID_EX;
      fwd_b_q    <= FWD_ID_EX;
      mem_dest_q <= 5'd0;
      mem_rw_q   <= 1'b0;
      wb_dest_q  <= 5'd0;
      wb_rw_q    <= 1'b0;
      md_busy_q  <= 1'b0;
`ifdef HAZARD_MULDIV_EN
      md_cnt_q   <= 2'd0;
`endif
    end else begin
      state_q    <= state_d;
      fwd_a_q    <= fwd_a_d;
      fwd_b_q    <= fwd_b_d;
      mem_dest_q <= mem_dest_d;
      mem_rw_q   <= mem_rw_d;
      wb_dest_q  <= wb_dest_d;
      wb_rw_q    <= wb_rw_d;
      md_busy_q  <= md_busy_d;
`ifdef HAZARD_MULDIV_EN
      md_cnt_q   <= md_cnt_d;
`endif
    end
  end

  // Reset masks the combinational controls so an aborted stall never leaks out.
  assign hif.stall   = stall_raw_s && !rst;
  assign hif.flush   = flush_raw_s && !rst;
  assign hif.fwdA    = fwd_a_q;
  assign hif.fwdB    = fwd_b_q;
  assign hif.md_busy = md_busy_q;
  assign hif.wb_dest = wb_dest_q;
  assign hif.wb_rw   = wb_rw_q;

endmodule
